// File: rtl/sync_fifo_param_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_param_pkg
// Shared defaults and constants for the parametrised synchronous FIFO.
// Holds the default word width, pointer width and almost-full/almost-empty
// thresholds. Also holds the read-mode selector values and a depth helper.
// -----------------------------------------------------------------------------
package sync_fifo_param_pkg;

    localparam int DefDataW    = 8;
    localparam int DefAddrW    = 6;
    localparam int DefAfThresh = 60;
    localparam int DefAeThresh = 4;

    // Read-mode selector values for the FWFT parameter
    localparam int FwftOff = 0;
    localparam int FwftOn  = 1;

    // Number of storage entries for a given pointer width
    function automatic int fifoDepth(input int addrW);
        return 1 << addrW;
    endfunction

endpackage

// File: rtl/sync_fifo_param_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem_2p
// Simple dual-port register array with no reset: one synchronous write port
// and one asynchronous read port. The FIFO control logic decides when writes
// happen and where reads point.
// Ports:
//   clk_i     clock, write on rising edge
//   we_i      write enable
//   wrAddr_i  write address
//   wrData_i  write data
//   rdAddr_i  read address (combinational read)
//   rdData_o  read data
// -----------------------------------------------------------------------------
module fifo_mem_2p
    import sync_fifo_param_pkg::*;
#(
    parameter int DATA_W = DefDataW,
    parameter int ADDR_W = DefAddrW
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wrAddr_i,
    input  logic [DATA_W-1:0] wrData_i,
    input  logic [ADDR_W-1:0] rdAddr_i,
    output logic [DATA_W-1:0] rdData_o
);

    localparam int DEPTH = fifoDepth(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage contents are deliberately left unreset; valid data is
    // tracked entirely by the pointers and count in the parent.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[wrAddr_i] <= wrData_i;
        end
    end

    assign rdData_o = mem[rdAddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Parametrised single-clock FIFO with almost-full/almost-empty thresholds,
// an optional first-word-fall-through read mode, a synchronous flush, a
// read-valid strobe and sticky overflow/underflow flags.
// Ports:
//   clk, rst (async, active-high), clr (sync flush)
//   wr_en/wr_data      write request and data
//   rd_en              read request (pop of head word in FWFT mode)
//   rd_data/rd_valid   read data and its valid strobe
//   count              stored words, 0..DEPTH
//   full/empty/almost_full/almost_empty   decodes of count
//   overflow/underflow sticky rejected-write / rejected-read flags
// -----------------------------------------------------------------------------
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter int DATA_W    = DefDataW,
    parameter int ADDR_W    = DefAddrW,
    parameter int AF_THRESH = DefAfThresh,
    parameter int AE_THRESH = DefAeThresh,
    parameter int FWFT      = FwftOff
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int DEPTH = fifoDepth(ADDR_W);

    logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              rdOk, wrOk;
    logic [DATA_W-1:0] memRdData;

    // Flags come only from the registered count, so they are glitch-free
    // with respect to this cycle's requests.
    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_W'(DEPTH));
    assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
    assign almost_empty = (count_q <= CNT_W'(AE_THRESH));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A write into a full FIFO is only allowed when a read frees a slot in
    // the same cycle; a read from an empty FIFO is never allowed, even if a
    // write arrives alongside it.
    assign rdOk = rd_en & ~empty;
    assign wrOk = wr_en & (~full | rdOk);

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) uMem (
        .clk_i    (clk),
        .we_i     (wrOk & ~clr),
        .wrAddr_i (wrPtr_q),
        .wrData_i (wr_data),
        .rdAddr_i (rdPtr_q),
        .rdData_o (memRdData)
    );

    // Pointer, count and sticky error next-state; flush overrides everything.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (wr_en & ~wrOk);
        underflow_d = underflow_q | (rd_en & empty);
        if (clr) begin
            wrPtr_d     = '0;
            rdPtr_d     = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wrOk) begin
                wrPtr_d = wrPtr_q + ADDR_W'(1);
            end
            if (rdOk) begin
                rdPtr_d = rdPtr_q + ADDR_W'(1);
            end
            case ({wrOk, rdOk})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    if (FWFT == FwftOff) begin : gRegRead
        logic [DATA_W-1:0] rdData_q, rdData_d;
        logic              rdValid_q, rdValid_d;

        // Registered read: the popped word appears one cycle after rd_en.
        // The data holds across idle cycles and flushes.
        always_comb begin
            rdData_d  = rdData_q;
            rdValid_d = 1'b0;
            if (!clr && rdOk) begin
                rdData_d  = memRdData;
                rdValid_d = 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdData_q  <= '0;
                rdValid_q <= 1'b0;
            end else begin
                rdData_q  <= rdData_d;
                rdValid_q <= rdValid_d;
            end
        end

        assign rd_data  = rdData_q;
        assign rd_valid = rdValid_q;
    end else begin : gFwftRead
        // Head word is presented directly; rd_en only acknowledges it.
        assign rd_data  = memRdData;
        assign rd_valid = ~empty;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// Directed plus randomised bench for sync_fifo_param. Instance uReg uses the
// registered read mode and is checked against a queue model. Instance uFwft
// uses first-word-fall-through mode.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       clrA = 1'b0, wrEnA = 1'b0, rdEnA = 1'b0;
    logic [7:0] wrDataA = '0;
    logic [7:0] rdDataA;
    logic       rdValidA, fullA, emptyA, afA, aeA, ovA, unA;
    logic [6:0] countA;

    logic       clrB = 1'b0, wrEnB = 1'b0, rdEnB = 1'b0;
    logic [7:0] wrDataB = '0;
    logic [7:0] rdDataB;
    logic       rdValidB, fullB, emptyB, afB, aeB, ovB, unB;
    logic [6:0] countB;

    int         nChecks = 0;
    int         nFail   = 0;

    logic [7:0] sb[$];
    logic [7:0] lastData = '0;
    bit         expOv = 1'b0;
    bit         expUn = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_param #(.FWFT(0)) uReg (
        .clk(clk), .rst(rst), .clr(clrA), .wr_en(wrEnA), .wr_data(wrDataA),
        .rd_en(rdEnA), .rd_data(rdDataA), .rd_valid(rdValidA), .count(countA),
        .full(fullA), .empty(emptyA), .almost_full(afA), .almost_empty(aeA),
        .overflow(ovA), .underflow(unA)
    );

    sync_fifo_param #(.FWFT(1)) uFwft (
        .clk(clk), .rst(rst), .clr(clrB), .wr_en(wrEnB), .wr_data(wrDataB),
        .rd_en(rdEnB), .rd_data(rdDataB), .rd_valid(rdValidB), .count(countB),
        .full(fullB), .empty(emptyB), .almost_full(afB), .almost_empty(aeB),
        .overflow(ovB), .underflow(unB)
    );

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp)
        else begin
            nFail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Compare the registered-read instance's status outputs with the model.
    task automatic checkStatusA();
        int n;
        n = sb.size();
        checkOutput("countA", 32'(countA), 32'(n));
        checkOutput("emptyA", 32'(emptyA), 32'(n == 0));
        checkOutput("fullA", 32'(fullA), 32'(n == 64));
        checkOutput("almostFullA", 32'(afA), 32'(n >= 60));
        checkOutput("almostEmptyA", 32'(aeA), 32'(n <= 4));
        checkOutput("overflowA", 32'(ovA), 32'(expOv));
        checkOutput("underflowA", 32'(unA), 32'(expUn));
    endtask

    // One clock of stimulus on the registered-read instance. The model
    // decides acceptance from its own occupancy and queues expected data.
    task automatic applyStimulus(input bit wr, input logic [7:0] d, input bit rd, input bit clr);
        bit mEmpty, mFull, rdOk, wrOk;
        mEmpty = (sb.size() == 0);
        mFull  = (sb.size() == 64);
        rdOk   = 1'b0;
        if (clr) begin
            sb.delete();
            expOv = 1'b0;
            expUn = 1'b0;
        end else begin
            rdOk  = rd & !mEmpty;
            wrOk  = wr & (!mFull | rdOk);
            expOv = expOv | (wr & !wrOk);
            expUn = expUn | (rd & mEmpty);
            if (rdOk) lastData = sb.pop_front();
            if (wrOk) sb.push_back(d);
        end
        wrEnA   = wr;
        wrDataA = d;
        rdEnA   = rd;
        clrA    = clr;
        @(posedge clk);
        #1;
        checkStatusA();
        checkOutput("rdValidA", 32'(rdValidA), 32'(rdOk));
        checkOutput("rdDataA", 32'(rdDataA), 32'(lastData));
    endtask

    initial begin
        // Reset state of both instances
        #12;
        checkStatusA();
        checkOutput("rstRdDataA", 32'(rdDataA), 32'h0);
        checkOutput("rstRdValidA", 32'(rdValidA), 32'h0);
        checkOutput("rstEmptyB", 32'(emptyB), 32'h1);
        checkOutput("rstRdValidB", 32'(rdValidB), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Mid-stream reset discards stored words and the in-flight write
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        wrEnA   = 1'b1;
        wrDataA = 8'h77;
        #3;
        rst = 1'b1;
        #1;
        sb.delete();
        lastData = '0;
        expOv    = 1'b0;
        expUn    = 1'b0;
        checkStatusA();
        checkOutput("midRstRdDataA", 32'(rdDataA), 32'h0);
        checkOutput("midRstRdValidA", 32'(rdValidA), 32'h0);
        @(negedge clk);
        rst   = 1'b0;
        wrEnA = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

        // Fill 0x00..0x3F, then drain in order
        for (int i = 0; i < 64; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        // Boundaries: overflow at full, write+read at full, underflow at empty
        for (int i = 0; i < 64; i++) applyStimulus(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hF0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
        for (int i = 0; i < 64; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // Flush with concurrent requests, then a clean write/read
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h99, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        // Random traffic across pointer wrap
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                          1'($urandom_range(0, 1)), 1'b0);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

        // First-word-fall-through instance
        wrEnB   = 1'b1;
        wrDataB = 8'hA5;
        @(posedge clk);
        #1;
        wrEnB = 1'b0;
        checkOutput("fwftData", 32'(rdDataB), 32'hA5);
        checkOutput("fwftValid", 32'(rdValidB), 32'h1);
        checkOutput("fwftCount", 32'(countB), 32'h1);
        @(posedge clk);
        #1;
        checkOutput("fwftHoldData", 32'(rdDataB), 32'hA5);
        checkOutput("fwftHoldValid", 32'(rdValidB), 32'h1);
        rdEnB = 1'b1;
        @(posedge clk);
        #1;
        rdEnB = 1'b0;
        checkOutput("fwftPopEmpty", 32'(emptyB), 32'h1);
        checkOutput("fwftPopValid", 32'(rdValidB), 32'h0);
        checkOutput("fwftUnderflow", 32'(unB), 32'h0);
        wrEnB   = 1'b1;
        wrDataB = 8'hB1;
        @(posedge clk);
        #1;
        wrDataB = 8'hB2;
        @(posedge clk);
        #1;
        wrEnB = 1'b0;
        checkOutput("fwftHeadFirst", 32'(rdDataB), 32'hB1);
        rdEnB = 1'b1;
        @(posedge clk);
        #1;
        rdEnB = 1'b0;
        checkOutput("fwftHeadSecond", 32'(rdDataB), 32'hB2);
        checkOutput("fwftCountOne", 32'(countB), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
